instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch stage feeding the decode path: holds the PC and issues word requests to
//   instruction memory, one outstanding at a time.
//   Buffers returned words with their PC in a small FIFO. Presents them to decode with
//   a valid/ready handshake; decode slices curr_instr[31:20] for immediate sign extension.
//   Supports PC redirect (branch/jump) with flush and discard of in-flight fetches.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC loaded at reset; first fetch address after start_i
//   FIFO_DEPTH  2              instruction buffer entries (power of two, >=2)
// PORTS
//   clk_i            in   1   clock, rising edge
//   rst_i            in   1   asynchronous, active-low reset
//   start_i          in   1   level; leaves IDLE when 1 (sampled each clock)
//   imem_req_o       out  1   fetch request, 1-cycle pulse, accepted same cycle
//   imem_addr_o      out  32  word address of request (bits[1:0] always 0)
//   imem_rvalid_i    in   1   response valid, >=1 cycle after request
//   imem_rdata_i     in   32  response instruction word
//   redirect_i       in   1   1-cycle pulse: flush and refetch from redirect_pc_i
//   redirect_pc_i    in   32  new PC; bits[1:0] forced to 0
//   instr_valid_o    out  1   FIFO head valid
//   instr_o          out  32  FIFO head instruction (curr_instr)
//   instr_pc_o       out  32  PC of FIFO head
//   instr_ready_i    in   1   decode accepts head when valid&ready
// BEHAVIOUR
//   Reset (rst_i=0, async):
//   - state=IDLE; pc_q=RESET_PC; FIFO empty; outstanding=0; discard=0.
//   - Outputs: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0.
//   States:
//   - IDLE: no requests. ->FETCH when start_i=1.
//   - FETCH: imem_req_o=(count+outstanding<FIFO_DEPTH), combinational from registers;
//     imem_addr_o=pc_q. On issue: pc_q+=4 (wraps 32'hFFFF_FFFC->0), outstanding=1, ->WAIT.
//   - WAIT: no request. On imem_rvalid_i:
//     - discard=0: push {pc,rdata} into FIFO.
//     - discard=1: drop the word and clear discard.
//     - Then outstanding=0, ->FETCH.
//   - start_i deasserting after IDLE has no effect; only reset returns to IDLE.
//   Latency and throughput:
//   - Request in cycle N, rvalid in N+1: instr_valid_o=1 in N+2.
//   - Next request in N+2. Peak throughput 1 instr per 2 cycles.
//   FIFO:
//   - instr_valid_o=(count!=0). instr_o/instr_pc_o show the head and are stable while
//     valid&!ready.
//   - Push and pop in the same cycle keep count unchanged.
//   - Overflow is impossible: issue requires count+outstanding<FIFO_DEPTH.
//   - Full FIFO blocks requests. Empty FIFO: instr_o keeps its last value, valid=0.
//   Redirect (highest priority):
//   - FIFO flushed (count=0); any same-cycle pop and push are ignored.
//   - pc_q={redirect_pc_i[31:2],2'b00}.
//   - outstanding=1 without rvalid in the same cycle: discard=1, stay WAIT.
//   - rvalid arriving in the redirect cycle: word dropped, ->FETCH, discard=0.
//   - Redirect in FETCH with a same-cycle issue: the request is suppressed (imem_req_o
//     forced 0), so no stale fetch occurs.
//   - Redirect in IDLE updates pc_q only.
//   - First valid after redirect (no outstanding): request in N+1, valid in N+3 at
//     1-cycle memory latency.
//   imem_rvalid_i while outstanding=0 is ignored.
//   Reset mid-operation: all state cleared immediately; any later memory response is
//   ignored (outstanding=0).
// TESTING
//   1. Reset, start_i=1, 1-cycle memory, ready=1 -> fetch addrs 0,4,8,...; instr_pc_o
//      0,4,8; one valid every 2 cycles.
//   2. ready=0 after start -> exactly 2 requests (0,4), FIFO full, imem_req_o stays 0;
//      head instr_pc_o=0 stable. Set ready=1 -> fetch resumes at 8.
//   3. Redirect to 32'h0000_0102 while request for 8 is outstanding -> rdata for 8 dropped;
//      next request addr 32'h100; first valid instr_pc_o=32'h100.
//   4. Redirect in the same cycle as rvalid and pop with FIFO holding 2 -> count=0, word
//      dropped, next addr=redirect PC.
//   5. RESET_PC=32'hFFFF_FFFC -> fetch FFFF_FFFC then 0000_0000 (wrap).
//   6. rst_i low while outstanding, then release and start -> stale rvalid ignored;
//      first addr=RESET_PC; instr_valid_o=0 during reset.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one word request at a time to
// instruction memory, buffers returned words with their PC in a small FIFO and
// hands them to decode over a valid/ready handshake. A redirect flushes the
// buffer, reloads the PC and discards any fetch still in flight.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0]   instr_mem_q [FIFO_DEPTH];
    logic [31:0]   pc_mem_q    [FIFO_DEPTH];
    logic [31:0]   last_instr_q;
    logic [31:0]   last_pc_q;

    logic          outstanding_s;
    logic          head_valid_s;
    logic          room_s;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic          unused_pc_lsb_s;

    // The only outstanding fetch is the one being waited on.
    assign outstanding_s   = (state_q == S_WAIT);
    assign head_valid_s    = (count_q != {CW{1'b0}});
    assign room_s          = ({1'b0, count_q} + {{CW{1'b0}}, outstanding_s}) < {1'b0, DEPTH_C};
    // A redirect suppresses the request so no stale address is fetched.
    assign issue_s         = (state_q == S_FETCH) && room_s && !redirect_i;
    assign push_s          = outstanding_s && imem_rvalid_i && !discard_q && !redirect_i;
    assign pop_s           = head_valid_s && instr_ready_i && !redirect_i;
    assign unused_pc_lsb_s = ^redirect_pc_i[1:0];

    assign imem_req_o    = issue_s;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = head_valid_s;
    // When empty the last delivered word is held so decode never sees garbage.
    assign instr_o       = head_valid_s ? instr_mem_q[rd_ptr_q] : last_instr_q;
    assign instr_pc_o    = head_valid_s ? pc_mem_q[rd_ptr_q]    : last_pc_q;

    // Next-state logic for the fetch FSM, PC and FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = issue_s ? pc_q : fetch_pc_q;
        discard_d  = discard_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (redirect_i) begin
            count_d  = {CW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            wr_ptr_d = {AW{1'b0}};
            pc_d     = {redirect_pc_i[31:2], 2'b00};
            if (outstanding_s) begin
                if (imem_rvalid_i) begin
                    state_d   = S_FETCH;
                    discard_d = 1'b0;
                end else begin
                    discard_d = 1'b1;
                end
            end else begin
                state_d = state_q;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FETCH: begin
                    if (issue_s) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        discard_d = 1'b0;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
            if (push_s && !pop_s) begin
                count_d = count_q + CW'(1);
            end else if (pop_s && !push_s) begin
                count_d = count_q - CW'(1);
            end else begin
                count_d = count_q;
            end
            wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
            rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        end
    end

    // Control registers: FSM state, PC, discard flag and FIFO pointers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
            count_q    <= {CW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Instruction buffer storage and the hold register for the last delivered word.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_q[i] <= 32'h0;
                pc_mem_q[i]    <= 32'h0;
            end
            last_instr_q <= 32'h0;
            last_pc_q    <= 32'h0;
        end else begin
            if (push_s) begin
                instr_mem_q[wr_ptr_q] <= imem_rdata_i;
                pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            end
            if (pop_s) begin
                last_instr_q <= instr_mem_q[rd_ptr_q];
                last_pc_q    <= pc_mem_q[rd_ptr_q];
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed tests push expected
// {pc, instr} pairs; a monitor pops and compares on every decode handshake.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n, start, req, rvalid, redirect, valid, ready;
    logic [31:0] addr, rdata, redirect_pc, instr, instr_pc;
    logic        w_start, w_req, w_rvalid, w_valid, w_ready, w_redirect;
    logic [31:0] w_addr, w_rdata, w_instr, w_instr_pc, w_redirect_pc;

    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   lat = 1;
    logic inj = 1'b0;

    typedef struct {int due; logic [31:0] data;} resp_t;
    typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
    resp_t       due_q[$];
    exp_t        exp_q[$];
    logic [31:0] obs_addr[$];
    int          obs_cyc[$];
    int          hs_cyc[$];
    logic [31:0] w_obs[$];
    logic [31:0] w_hs[$];
    logic        w_pend;
    logic [31:0] w_pdata;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .imem_req_o(req), .imem_addr_o(addr),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(instr_pc),
        .instr_ready_i(ready)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) u_dut_wrap (
        .clk_i(clk), .rst_i(rst_n), .start_i(w_start),
        .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
        .redirect_i(w_redirect), .redirect_pc_i(w_redirect_pc),
        .instr_valid_o(w_valid), .instr_o(w_instr), .instr_pc_o(w_instr_pc),
        .instr_ready_i(w_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc_v);
        exp_q.push_back('{pc_v, mem_word(pc_v)});
    endtask

    task automatic wait_addrs(input int n, input int budget, input string name);
        int k = 0;
        while (obs_addr.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check(name, 32'(obs_addr.size()), 32'(n));
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k = 0;
        while (exp_q.size() > 0 && k < budget) begin
            tick(1);
            k++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        start = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        inj = 1'b0; lat = 1;
        rst_n = 1'b0;
        tick(6);
        rst_n = 1'b1;
        exp_q.delete(); obs_addr.delete(); obs_cyc.delete(); hs_cyc.delete();
        tick(1);
    endtask

    // Memory model for the main instance: programmable latency plus injectable spurious rvalid.
    initial begin
        rvalid = 1'b0; rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            rvalid = inj;
            rdata  = 32'hDEAD_BEEF;
            if (due_q.size() > 0 && due_q[0].due <= cyc) begin
                rdata  = due_q[0].data;
                rvalid = 1'b1;
                void'(due_q.pop_front());
            end
            #6;
            if (req) due_q.push_back('{cyc + lat, mem_word(addr)});
        end
    end

    // Memory model and recorder for the wrap-around instance (1-cycle latency).
    initial begin
        w_rvalid = 1'b0; w_rdata = 32'h0; w_pend = 1'b0; w_pdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            w_rvalid = w_pend;
            w_rdata  = w_pdata;
            #6;
            w_pend  = w_req;
            w_pdata = mem_word(w_addr);
            if (w_req) w_obs.push_back(w_addr);
            if (w_valid && w_ready) w_hs.push_back(w_instr_pc);
        end
    end

    // Monitor: records requests and compares each handshake against the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #8;
            if (req) begin
                obs_addr.push_back(addr);
                obs_cyc.push_back(cyc);
            end
            if (valid && ready && !redirect) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("head_pc", instr_pc, e.pc);
                    check("head_instr", instr, e.instr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        w_start = 1'b0; w_ready = 1'b1; w_redirect = 1'b0; w_redirect_pc = 32'h0;
        tick(3);
        check("rst_req", {31'h0, req}, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);

        // 1: streaming with 1-cycle memory
        do_reset();
        ready = 1'b1; start = 1'b1;
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
        wait_drain(30, "t1_drain");
        check("t1_addr0", obs_addr[0], 32'h0);
        check("t1_addr1", obs_addr[1], 32'h4);
        check("t1_addr2", obs_addr[2], 32'h8);
        check("t1_addr3", obs_addr[3], 32'hC);
        check("t1_latency", 32'(hs_cyc[0] - obs_cyc[0]), 32'd2);
        check("t1_rate01", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);
        check("t1_rate12", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);

        // 2: decode stalled, FIFO fills and blocks requests
        do_reset();
        start = 1'b1;
        tick(12);
        check("t2_nreq", 32'(obs_addr.size()), 32'd2);
        check("t2_addr0", obs_addr[0], 32'h0);
        check("t2_addr1", obs_addr[1], 32'h4);
        check("t2_req_blocked", {31'h0, req}, 32'h0);
        check("t2_valid", {31'h0, valid}, 32'h1);
        check("t2_head_pc", instr_pc, 32'h0);
        check("t2_head_instr", instr, mem_word(32'h0));
        tick(3);
        check("t2_head_stable", instr_pc, 32'h0);
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        ready = 1'b1;
        wait_drain(20, "t2_drain");
        check("t2_resume_addr", obs_addr[2], 32'h8);

        // 3: redirect while a fetch is outstanding (2-cycle memory)
        do_reset();
        lat = 2; ready = 1'b1; start = 1'b1;
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h100); push_exp(32'h104);
        wait_addrs(3, 30, "t3_wait_req8");
        check("t3_addr2", obs_addr[2], 32'h8);
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        tick(1);
        redirect = 1'b0;
        wait_drain(40, "t3_drain");
        check("t3_addr3", obs_addr[3], 32'h100);

        // 4a: redirect in the cycle the outstanding word returns
        do_reset();
        ready = 1'b1; start = 1'b1;
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h200); push_exp(32'h204);
        wait_addrs(3, 30, "t4a_wait_req8");
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick(1);
        redirect = 1'b0;
        #1;
        check("t4a_req", {31'h0, req}, 32'h1);
        check("t4a_addr", addr, 32'h200);
        wait_drain(30, "t4a_drain");

        // 4b: redirect with full FIFO, same-cycle pop and spurious rvalid
        do_reset();
        start = 1'b1;
        tick(12);
        check("t4b_full_pc", instr_pc, 32'h0);
        push_exp(32'h300); push_exp(32'h304);
        ready = 1'b1; inj = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0303;
        tick(1);
        redirect = 1'b0; inj = 1'b0;
        #1;
        check("t4b_flushed", {31'h0, valid}, 32'h0);
        check("t4b_req", {31'h0, req}, 32'h1);
        check("t4b_addr", addr, 32'h300);
        wait_drain(30, "t4b_drain");

        // 4c: redirect on the cycle of an issue suppresses the request
        do_reset();
        ready = 1'b1; start = 1'b1;
        tick(1);
        redirect = 1'b1; redirect_pc = 32'h0000_0400;
        #1;
        check("t4c_req_suppressed", {31'h0, req}, 32'h0);
        tick(1);
        redirect = 1'b0;
        #1;
        check("t4c_req", {31'h0, req}, 32'h1);
        check("t4c_addr", addr, 32'h400);
        push_exp(32'h400);
        wait_drain(20, "t4c_drain");
        check("t4c_first_addr", obs_addr[0], 32'h400);

        // 5: PC wrap from the top of the address space
        w_start = 1'b1;
        tick(10);
        check("t5_addr0", w_obs[0], 32'hFFFF_FFFC);
        check("t5_addr1", w_obs[1], 32'h0);
        check("t5_pc0", w_hs[0], 32'hFFFF_FFFC);
        check("t5_pc1", w_hs[1], 32'h0);

        // 6: reset while a fetch is outstanding; its late response must be ignored
        do_reset();
        lat = 4; start = 1'b1;
        wait_addrs(2, 40, "t6_wait_req4");
        check("t6_pre_valid", {31'h0, valid}, 32'h1);
        rst_n = 1'b0; start = 1'b0;
        #1;
        check("t6_rst_valid", {31'h0, valid}, 32'h0);
        check("t6_rst_req", {31'h0, req}, 32'h0);
        check("t6_rst_addr", addr, 32'h0);
        check("t6_rst_instr", instr, 32'h0);
        tick(1);
        rst_n = 1'b1; lat = 1;
        obs_addr.delete(); exp_q.delete();
        tick(5);
        check("t6_stale_ignored", {31'h0, valid}, 32'h0);
        check("t6_no_req", 32'(obs_addr.size()), 32'd0);
        ready = 1'b1; start = 1'b1;
        push_exp(32'h0); push_exp(32'h4);
        wait_drain(30, "t6_drain");
        check("t6_first_addr", obs_addr[0], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
